mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
//  Execute-stage control for the iterative 32x32 multiplier (M extension).
//  Accepts a MUL-class op from ID/EX, converts operands to unsigned magnitudes, starts the multiplier and stalls the pipeline.
//  On completion it sign-corrects the 64-bit product, selects the low or high word, and returns a 32-bit result for the EX/MEM register.
//  Sits between the ID/EX pipeline register and the multiplier; the multiplier always sees an unsigned multiply.
// PARAMETERS
//  XLEN      32   operand/result width; product width is 2*XLEN
// PORTS
//  clk               input   1        clock, rising edge
//  rst               input   1        asynchronous reset, active-low (0 = reset)
//  mul_validE        input   1        MUL-class instruction present in EX
//  mul_opcodeE       input   2        00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  rs1E              input   XLEN     operand 1
//  rs2E              input   XLEN     operand 2
//  flushE            input   1        squash EX-stage instruction
//  mul_start         output  1        one-cycle start pulse to multiplier
//  mul_op1           output  XLEN     |operand1| (unsigned magnitude)
//  mul_op2           output  XLEN     |operand2| (unsigned magnitude)
//  mul_product       input   2*XLEN   unsigned product from multiplier
//  mul_ready         input   1        multiplier done; product valid
//  stall_mul         output  1        hold IF/ID/EX, insert bubble into MEM
//  mul_resultE       output  XLEN     final result to EX/MEM
//  mul_result_valid  output  1        mul_resultE valid this cycle
// BEHAVIOUR
//  FSM states and transitions:
//   IDLE -> START when mul_validE & ~flushE.
//   START -> WAIT.
//   WAIT -> FIXUP on mul_ready.
//   FIXUP -> DONE.
//   DONE -> IDLE.
//  Reset (rst=0, async):
//   state=IDLE; all outputs 0; operand/sign/product registers cleared.
//  IDLE:
//   On accept, latch op1/op2 magnitudes, sign1, sign2, opcode.
//   stall_mul = mul_validE & ~flushE, combinational, same cycle as mul_validE.
//  Sign rules:
//   sign1 = rs1E[XLEN-1] for opcodes 00/01/10, else 0.
//   sign2 = rs2E[XLEN-1] for opcodes 00/01, else 0.
//   Magnitude = sign ? (~x + 1) : x. 0x80000000 -> magnitude 0x80000000 (fits unsigned).
//  START:
//   mul_start=1 for exactly one cycle; mul_op1/op2 held stable from START until leaving WAIT.
//  WAIT:
//   mul_ready is sampled only in WAIT; a stale ready seen in IDLE/START is ignored.
//   No timeout.
//  FIXUP:
//   Register P = (sign1^sign2) ? (~mul_product + 1) : mul_product, 64-bit two's complement.
//   Result = P[XLEN-1:0] for MUL, else P[2*XLEN-1:XLEN].
//  DONE:
//   mul_result_valid=1, mul_resultE=result, stall_mul=0; the instruction advances at this edge.
//   mul_resultE holds until the next DONE; mul_result_valid is 0 in all other states.
//  Latency:
//   stall_mul=1 from the IDLE-accept cycle through FIXUP.
//   Minimum 4 stall cycles (ready in first WAIT cycle); back-to-back ops are re-accepted in the IDLE after DONE.
//  flushE in any state:
//   Next state IDLE, stall_mul=0 in that cycle, no mul_result_valid.
//   An in-flight multiplier run is abandoned; its later ready is ignored per the WAIT rule.
//   flushE has priority over mul_ready.
//  mul_validE deasserting while busy is ignored; only flushE aborts.
//  Reset asserted mid-operation: immediate IDLE with outputs 0; no start pulse is reissued after release.
// TESTING
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> product 0xFFFFFFFE00000001, mul_resultE=0xFFFFFFFE.
//  MUL rs1=-3 (0xFFFFFFFD), rs2=7 -> mul_op1=3, mul_op2=7, mul_resultE=0xFFFFFFEB; same operands via MULH -> 0xFFFFFFFF.
//  MULHSU 0x80000000*0xFFFFFFFF -> P=0x8000000080000000, mul_resultE=0x80000000; MULH 0x80000000*0x80000000 -> 0x40000000.
//  Multiplier model ready 1 cycle after start -> stall_mul high exactly 4 cycles, result_valid 1 cycle; repeat after N=33 -> 36 stall cycles.
//  flushE in 2nd WAIT cycle, model asserts ready 3 cycles later -> stall drops in flush cycle, no result_valid; next op MUL 5*6 -> 30.
//  rst=0 during WAIT -> stall_mul, mul_start, mul_result_valid, mul_resultE all 0 before next clock edge; after release, new MUL 2*2 -> 4.

Source files
------------

// File: rtl/mul_issue_ctrl_if.sv
// EX-stage <-> multiplier control bundle; master is the pipeline/multiplier side, slave is mul_issue_ctrl.
// Pure wiring, no latency; backpressure is carried by stall_mul towards the pipeline.
interface mul_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic              mul_validE;
    logic [1:0]        mul_opcodeE;
    logic [XLEN-1:0]   rs1E;
    logic [XLEN-1:0]   rs2E;
    logic              flushE;
    logic              mul_start;
    logic [XLEN-1:0]   mul_op1;
    logic [XLEN-1:0]   mul_op2;
    logic [2*XLEN-1:0] mul_product;
    logic              mul_ready;
    logic              stall_mul;
    logic [XLEN-1:0]   mul_resultE;
    logic              mul_result_valid;

    modport master (
        output mul_validE, mul_opcodeE, rs1E, rs2E, flushE, mul_product, mul_ready,
        input  mul_start, mul_op1, mul_op2, stall_mul, mul_resultE, mul_result_valid
    );

    modport slave (
        input  mul_validE, mul_opcodeE, rs1E, rs2E, flushE, mul_product, mul_ready,
        output mul_start, mul_op1, mul_op2, stall_mul, mul_resultE, mul_result_valid
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Sign-magnitude wrapper around an unsigned iterative multiplier for MUL/MULH/MULHSU/MULHU.
// Latency: accept, START, WAIT (>=1), FIXUP, DONE; stall_mul holds the pipeline until DONE, flushE aborts.
module mul_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    mul_issue_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     op1_q;
    logic [XLEN-1:0]     op2_q;
    logic [XLEN-1:0]     res_q;
    logic [2*XLEN-1:0]   prod_q;
    logic                neg_q;
    logic                is_mul_q;
    logic                start_q;
    logic                done_q;

    logic                accept;
    logic                busy;
    logic                sign1;
    logic                sign2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;

    assign accept = (state == S_IDLE) & bus.mul_validE & ~bus.flushE;
    assign busy   = (state == S_START) | (state == S_WAIT) | (state == S_FIXUP);

    // MULHU treats rs1 as unsigned; MULHSU and MULHU treat rs2 as unsigned.
    assign sign1 = (bus.mul_opcodeE != 2'b11) & bus.rs1E[XLEN-1];
    assign sign2 = ~bus.mul_opcodeE[1] & bus.rs2E[XLEN-1];
    assign mag1  = sign1 ? ({XLEN{1'b0}} - bus.rs1E) : bus.rs1E;
    assign mag2  = sign2 ? ({XLEN{1'b0}} - bus.rs2E) : bus.rs2E;

    // Reset also masks the accept term so a held mul_validE cannot raise stall during reset.
    assign bus.stall_mul        = rst & ~bus.flushE & (accept | busy);
    assign bus.mul_result_valid = done_q & ~bus.flushE;
    assign bus.mul_start        = start_q;
    assign bus.mul_op1          = op1_q;
    assign bus.mul_op2          = op2_q;
    assign bus.mul_resultE      = res_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            res_q    <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            is_mul_q <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.flushE) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.mul_validE) begin
                            state    <= S_START;
                            start_q  <= 1'b1;
                            op1_q    <= mag1;
                            op2_q    <= mag2;
                            neg_q    <= sign1 ^ sign2;
                            is_mul_q <= (bus.mul_opcodeE == 2'b00);
                        end
                    end
                    S_START: state <= S_WAIT;
                    S_WAIT: begin
                        // The product is only guaranteed on the ready cycle, so the
                        // sign correction is captured here and FIXUP works from prod_q.
                        if (bus.mul_ready) begin
                            state  <= S_FIXUP;
                            prod_q <= neg_q ? ({(2*XLEN){1'b0}} - bus.mul_product)
                                            : bus.mul_product;
                        end
                    end
                    S_FIXUP: begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                        res_q  <= is_mul_q ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed + randomized bench for mul_issue_ctrl with a latency-programmable multiplier model.
module tb_mul_issue_ctrl;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mul_issue_ctrl_if #(.XLEN(XLEN)) mif();
    mul_issue_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(mif));

    int total = 0;
    int bad   = 0;

    // Multiplier model: ready is high during the mdl_lat-th cycle after the start pulse.
    int          mdl_lat = 1;
    int          mdl_cnt;
    logic        mdl_busy;
    logic [63:0] mdl_prod;
    logic        stray_ready = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdl_busy <= 1'b0;
            mdl_cnt  <= 0;
            mdl_prod <= '0;
        end else if (mif.mul_start) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= mdl_lat;
            mdl_prod <= {32'd0, mif.mul_op1} * {32'd0, mif.mul_op2};
        end else if (mdl_busy) begin
            if (mdl_cnt == 1) mdl_busy <= 1'b0;
            else              mdl_cnt  <= mdl_cnt - 1;
        end
    end

    assign mif.mul_ready   = (mdl_busy && mdl_cnt == 1) || stray_ready;
    assign mif.mul_product = mdl_prod;

    // Architectural result: sign/zero-extend to 64 bits, multiply, pick a word.
    function automatic logic [31:0] ref_result(input logic [1:0] opc, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (opc != 2'b11) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (opc[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (opc == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] x, input bit sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in the low clock phase; leaves at negedge+1 of the cycle after DONE.
    task automatic do_op(input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit stray);
        logic [31:0] e_res, e_m1, e_m2;
        int stalls, starts;
        bit seen_done;
        e_res = ref_result(opc, a, b);
        e_m1  = mag(a, opc != 2'b11);
        e_m2  = mag(b, opc[1] == 1'b0);
        mdl_lat = lat;
        mif.mul_validE  = 1'b1;
        mif.mul_opcodeE = opc;
        mif.rs1E        = a;
        mif.rs2E        = b;
        stray_ready     = stray;
        stalls = 0; starts = 0; seen_done = 1'b0;
        for (int cyc = 0; cyc < lat + 12 && !seen_done; cyc++) begin
            #1;
            if (mif.stall_mul) stalls++;
            if (mif.mul_start) begin
                starts++;
                chk("mul_op1", mif.mul_op1, e_m1);
                chk("mul_op2", mif.mul_op2, e_m2);
            end
            if (mif.mul_ready && !stray_ready) begin
                chk("op1_held", mif.mul_op1, e_m1);
                chk("op2_held", mif.mul_op2, e_m2);
            end
            if (mif.mul_result_valid) begin
                seen_done = 1'b1;
                chk("result", mif.mul_resultE, e_res);
                chk("stall_in_done", mif.stall_mul, 0);
            end
            @(negedge clk);
            mif.mul_validE  = 1'b0;
            mif.rs1E        = $urandom;
            mif.rs2E        = $urandom;
            mif.mul_opcodeE = 2'($urandom);
            if (cyc >= 1) stray_ready = 1'b0;
        end
        chk("done_seen", seen_done, 1);
        chk("stall_cycles", stalls, lat + 3);
        chk("start_pulses", starts, 1);
        #1;
        chk("valid_after_done", mif.mul_result_valid, 0);
        chk("result_hold", mif.mul_resultE, e_res);
    endtask

    int bad_cycles;

    initial begin
        mif.mul_validE  = 1'b1;
        mif.mul_opcodeE = 2'b00;
        mif.rs1E        = 32'h1234_5678;
        mif.rs2E        = 32'h9abc_def0;
        mif.flushE      = 1'b0;
        #12;
        chk("rst_stall", mif.stall_mul, 0);
        chk("rst_start", mif.mul_start, 0);
        chk("rst_op1", mif.mul_op1, 0);
        chk("rst_op2", mif.mul_op2, 0);
        chk("rst_result", mif.mul_resultE, 0);
        chk("rst_valid", mif.mul_result_valid, 0);
        mif.mul_validE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 2, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b1);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 1'b0);
        do_op(2'b00, $urandom, $urandom, 33, 1'b0);

        // Flush while accepting: nothing may start.
        mif.mul_validE = 1'b1; mif.flushE = 1'b1; mif.mul_opcodeE = 2'b00;
        #1; chk("flush_accept_stall", mif.stall_mul, 0);
        @(negedge clk); mif.mul_validE = 1'b0; mif.flushE = 1'b0;
        #1; chk("flush_accept_nostart", mif.mul_start, 0);

        // Flush in the second WAIT cycle; the late ready must be ignored.
        mdl_lat = 5;
        mif.mul_validE = 1'b1; mif.mul_opcodeE = 2'b01; mif.rs1E = $urandom; mif.rs2E = $urandom;
        #1; chk("fl_accept_stall", mif.stall_mul, 1);
        @(negedge clk); mif.mul_validE = 1'b0;
        #1; chk("fl_start", mif.mul_start, 1);
        @(negedge clk);
        @(negedge clk); mif.flushE = 1'b1;
        #1;
        chk("fl_stall_drop", mif.stall_mul, 0);
        chk("fl_no_valid", mif.mul_result_valid, 0);
        @(negedge clk); mif.flushE = 1'b0;
        bad_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mif.stall_mul || mif.mul_result_valid || mif.mul_start) bad_cycles++;
            @(negedge clk);
        end
        chk("fl_quiet_after", bad_cycles, 0);
        do_op(2'b00, 32'd5, 32'd6, 2, 1'b0);

        // Reset in the middle of WAIT.
        mdl_lat = 10;
        mif.mul_validE = 1'b1; mif.mul_opcodeE = 2'b00; mif.rs1E = 32'd9; mif.rs2E = 32'd9;
        @(negedge clk); mif.mul_validE = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_mid_stall", mif.stall_mul, 0);
        chk("rst_mid_start", mif.mul_start, 0);
        chk("rst_mid_valid", mif.mul_result_valid, 0);
        chk("rst_mid_result", mif.mul_resultE, 0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (mif.stall_mul || mif.mul_result_valid || mif.mul_start) bad_cycles++;
            @(negedge clk);
        end
        chk("rst_no_restart", bad_cycles, 0);
        do_op(2'b00, 32'd2, 32'd2, 1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            do_op(2'($urandom), a, b, $urandom_range(1, 8), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
